// File: rtl/led_ctrl_pkg.sv
// Shared encodings, widths and defaults for the LED mode controller.
package led_ctrl_pkg;

   localparam int unsigned MODE_W       = 2;
   localparam int unsigned LED_W        = 16;
   localparam int unsigned TICK_DIV_DEF = 25_000_000;

   typedef enum logic [MODE_W-1:0] {
      MODE_PASS   = 2'd0,
      MODE_HOLD   = 2'd1,
      MODE_ROTATE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   typedef enum logic {
      PHASE_OFF = 1'b0,
      PHASE_ON  = 1'b1
   } phase_e;

   function automatic mode_e next_mode(input mode_e m);
      mode_e n;
      case (m)
         MODE_PASS:   n = MODE_HOLD;
         MODE_HOLD:   n = MODE_ROTATE;
         MODE_ROTATE: n = MODE_BLINK;
         default:     n = MODE_PASS;
      endcase
      return n;
   endfunction

   function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] v);
      return {v[LED_W-2:0], v[LED_W-1]};
   endfunction

endpackage

// File: rtl/led_mode_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_gen
   import led_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned     CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || (cnt_q == CNT_MAX)) begin
         cnt_d = '0;
      end
   end

   assign tick = (cnt_q == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_mode_ctrl.sv
// Switch/button driven LED controller: pass-through, hold, rotate and blink
// modes selected by BTNC, snapshot loaded by BTNU.
module led_mode_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LED_W-1:0]  SW,
   input  logic              BTNC,
   input  logic              BTNU,
   output logic [LED_W-1:0]  LED,
   output logic [MODE_W-1:0] MODE
);

   logic [LED_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [1:0]       btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [1:0]       btn_prev_q, btn_prev_d, armed_q, armed_d;
   logic [1:0]       vld_q, vld_d;
   logic [1:0]       btn_ev;
   logic             btnc_ev, btnu_ev;

   mode_e            mode_q, mode_d;
   phase_e           phase_q, phase_d;
   logic [LED_W-1:0] snap_q, snap_d, pat_q, pat_d, led_q, led_d;
   logic             tick, clr, tick_ok;

   // Bit 0 = BTNC, bit 1 = BTNU. vld tracks when the second sync stage holds a
   // real post-reset sample; a button only arms after being seen low, so one
   // held through reset release produces no event.
   always_comb begin
      sw_s1_d    = SW;
      sw_s2_d    = sw_s1_q;
      btn_s1_d   = {BTNU, BTNC};
      btn_s2_d   = btn_s1_q;
      btn_prev_d = btn_s2_q;
      vld_d      = {vld_q[0], 1'b1};
      armed_d    = armed_q | ({2{vld_q[1]}} & ~btn_s2_q);
   end

   assign btn_ev  = btn_s2_q & ~btn_prev_q & armed_q;
   assign btnc_ev = btn_ev[0];
   assign btnu_ev = btn_ev[1];
   assign clr     = btnc_ev | btnu_ev;
   assign tick_ok = tick & ~clr;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   always_comb begin
      mode_d  = mode_q;
      snap_d  = snap_q;
      pat_d   = pat_q;
      phase_d = phase_q;
      led_d   = led_q;

      if (btnc_ev) begin
         mode_d = next_mode(mode_q);
      end
      if (btnu_ev) begin
         snap_d = sw_s2_q;
      end

      // Entry and reload use snap_d so a simultaneous BTNU feeds the new mode.
      if (clr && (mode_d == MODE_ROTATE)) begin
         pat_d = snap_d;
      end else if (tick_ok && (mode_q == MODE_ROTATE)) begin
         pat_d = rotl1(pat_q);
      end

      if (clr && (mode_d == MODE_BLINK)) begin
         phase_d = PHASE_ON;
      end else if (tick_ok && (mode_q == MODE_BLINK)) begin
         phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end

      case (mode_q)
         MODE_PASS:   led_d = sw_s2_q;
         MODE_HOLD:   led_d = snap_q;
         MODE_ROTATE: led_d = pat_q;
         default:     led_d = (phase_q == PHASE_ON) ? snap_q : '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         btn_prev_q <= '0;
         armed_q    <= '0;
         vld_q      <= '0;
         mode_q     <= MODE_PASS;
         phase_q    <= PHASE_ON;
         snap_q     <= '0;
         pat_q      <= '0;
         led_q      <= '0;
      end else begin
         sw_s1_q    <= sw_s1_d;
         sw_s2_q    <= sw_s2_d;
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
         btn_prev_q <= btn_prev_d;
         armed_q    <= armed_d;
         vld_q      <= vld_d;
         mode_q     <= mode_d;
         phase_q    <= phase_d;
         snap_q     <= snap_d;
         pat_q      <= pat_d;
         led_q      <= led_d;
      end
   end

   assign LED  = led_q;
   assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with TICK_DIV=4; inputs change 1 ns after
// a rising edge, outputs are checked at that same point.
module tb_led_mode_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw;
   logic        btnc, btnu;
   logic [15:0] led;
   logic [1:0]  mode;

   int checks = 0;
   int errors = 0;

   led_mode_ctrl #(
      .TICK_DIV (4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .SW   (sw),
      .BTNC (btnc),
      .BTNU (btnu),
      .LED  (led),
      .MODE (mode)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic c, input logic u);
      btnc = c;
      btnu = u;
      cyc(1);
      btnc = 1'b0;
      btnu = 1'b0;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; sw = '0; btnc = 1'b0; btnu = 1'b0;
      cyc(3);
      check("rst_led", led, 16'h0000);
      check("rst_mode", {14'd0, mode}, 16'd0);
      rst = 1'b0;

      // PASS latency: sampled at k, visible at k+2
      sw = 16'hA5A5;
      cyc(2);
      check("pass_early", led, 16'h0000);
      cyc(1);
      check("pass_led", led, 16'hA5A5);
      check("pass_mode", {14'd0, mode}, 16'd0);

      // snapshot then HOLD
      sw = 16'h00F0;
      cyc(3);
      pulse(1'b0, 1'b1);
      cyc(2);
      pulse(1'b1, 1'b0);
      cyc(2);
      check("hold_mode", {14'd0, mode}, 16'd1);
      sw = 16'hFFFF;
      cyc(4);
      check("hold_led", led, 16'h00F0);

      // ROTATE: entry at k+2, first tick lands on k+6
      pulse(1'b1, 1'b0);
      cyc(2);
      check("rot_mode", {14'd0, mode}, 16'd2);
      cyc(1);
      check("rot_entry", led, 16'h00F0);
      cyc(3);
      check("rot_pre_tick", led, 16'h00F0);
      cyc(1);
      check("rot_1", led, 16'h01E0);
      cyc(4);
      check("rot_2", led, 16'h03C0);
      sw = 16'h8001;
      pulse(1'b0, 1'b1);
      cyc(2);
      cyc(1);
      check("rot_reload", led, 16'h8001);
      cyc(4);
      check("rot_wrap", led, 16'h0003);

      // BLINK
      pulse(1'b1, 1'b0);
      cyc(2);
      check("blink_mode", {14'd0, mode}, 16'd3);
      cyc(1);
      check("blink_on", led, 16'h8001);
      cyc(3);
      check("blink_on_late", led, 16'h8001);
      sw = 16'h5A5A;
      btnu = 1'b1;
      cyc(1);
      btnu = 1'b0;
      check("blink_off", led, 16'h0000);
      cyc(2);
      check("blink_btnu_k2", led, 16'h0000);
      cyc(1);
      check("blink_btnu_k3", led, 16'h5A5A);
      cyc(3);
      check("blink_clr_on", led, 16'h5A5A);
      cyc(1);
      check("blink_clr_off", led, 16'h0000);

      // simultaneous BTNC + BTNU
      sw = 16'h1234;
      pulse(1'b1, 1'b1);
      cyc(2);
      check("both_mode", {14'd0, mode}, 16'd0);
      sw = 16'h0000;
      cyc(3);
      pulse(1'b1, 1'b0);
      cyc(2);
      check("both_hold_mode", {14'd0, mode}, 16'd1);
      cyc(1);
      check("both_snap", led, 16'h1234);

      // held button gives one advance
      btnc = 1'b1;
      cyc(20);
      check("held_mode", {14'd0, mode}, 16'd2);
      btnc = 1'b0;
      cyc(3);
      check("held_release", {14'd0, mode}, 16'd2);

      // reset mid-ROTATE
      rst = 1'b1;
      cyc(1);
      check("midrst_led", led, 16'h0000);
      check("midrst_mode", {14'd0, mode}, 16'd0);

      // BTNC held through reset release
      btnc = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(10);
      check("held_rst_mode", {14'd0, mode}, 16'd0);
      btnc = 1'b0;
      cyc(4);
      pulse(1'b1, 1'b0);
      cyc(2);
      check("repress_mode", {14'd0, mode}, 16'd1);

      // all-zero snapshot stays zero under rotation
      pulse(1'b1, 1'b0);
      cyc(2);
      check("zero_rot_mode", {14'd0, mode}, 16'd2);
      cyc(9);
      check("zero_rot_led", led, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
